ram_arbiter_rr: RTL and testbench
=================================

Name: ram_arbiter_rr

Overview:
- Parametrised N-port to 1 arbiter in front of the unified SoC memory bus, using the OBI-style req/gnt/rvalid protocol.
- Generalises the two-port instruction/data arbiter:
  - NUM_PORTS masters instead of two.
  - Round-robin fairness instead of fixed priority.
  - Up to MAX_OUTSTANDING pipelined transactions in flight, with responses routed back in order through a port-ID FIFO.
- Sits between CPU/DMA/debug masters and the SoC RAM interconnect.

Parameters:
- NUM_PORTS, 2, number of master ports (2..16).
- SOC_ADDR_WIDTH, 32, address width.
- MAX_OUTSTANDING, 2, number of accepted transactions not yet answered by rvalid (1..8).
- IDX_W, $clog2(NUM_PORTS) (minimum 1), derived port-index width. Do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- m_req_i  in  NUM_PORTS  per-port request
- m_addr_i  in  NUM_PORTS x SOC_ADDR_WIDTH  per-port address (packed 2-D)
- m_we_i  in  NUM_PORTS  per-port write enable
- m_be_i  in  NUM_PORTS x 4  per-port byte enables
- m_wdata_i  in  NUM_PORTS x 32  per-port write data
- m_gnt_o  out  NUM_PORTS  per-port grant (one-hot or zero)
- m_rvalid_o  out  NUM_PORTS  per-port response valid (one-hot or zero)
- m_rdata_o  out  32  response data, shared by all ports, qualified by m_rvalid_o
- soc_req_o  out  1  bus request
- soc_gnt_i  in  1  bus grant
- soc_addr_o  out  SOC_ADDR_WIDTH  bus address
- soc_we_o  out  1  bus write enable
- soc_be_o  out  4  bus byte enables
- soc_wdata_o  out  32  bus write data
- soc_rvalid_i  in  1  bus response valid
- soc_rdata_i  in  32  bus response data
- err_o  out  1  sticky protocol error: rvalid received with no transaction outstanding

Behaviour:
- Reset (rst_ni low at a clk_i edge, synchronous):
  - FSM goes to ARB, rr_ptr = 0, ID FIFO empty, err_o = 0.
  - Combinational outputs are 0 while the reset state holds and no requests are present.
  - Reset mid-transaction discards all outstanding IDs; later soc_rvalid_i with an empty FIFO sets err_o.
- Winner selection (combinational): the first requesting port found scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
- FSM has two states:
  - ARB: winner = current round-robin pick.
  - LOCK: winner = locked_idx register. Keeps the bus signals stable while waiting for grant, so the OBI "address stable until gnt" rule holds even if a higher-priority port raises req.
- soc_req_o = m_req_i[winner] && !fifo_full. soc_addr_o, soc_we_o, soc_be_o and soc_wdata_o come from the winner. All of these are 0 when soc_req_o is low.
- m_gnt_o[winner] = soc_req_o && soc_gnt_i; all other grant bits are 0.
- Handshake (soc_req_o && soc_gnt_i):
  - Push winner index into the ID FIFO.
  - rr_ptr <= (winner+1) mod NUM_PORTS.
  - FSM goes to ARB.
  - Zero added latency: a grant in cycle N lets a new request issue in cycle N+1.
- Request without grant in ARB: locked_idx <= winner and FSM goes to LOCK. LOCK exits only on handshake.
- A master dropping req while in LOCK is a protocol violation of the master. The arbiter drops soc_req_o and stays in LOCK.
- Response path:
  - On soc_rvalid_i: m_rvalid_o[fifo_head] = 1, m_rdata_o = soc_rdata_i, and the FIFO pops in the same cycle.
  - m_rdata_o = 0 when no rvalid is present.
  - Responses are strictly in order.
- FIFO full: soc_req_o is held low even if a pop happens in the same cycle. This gives no combinational path from rvalid to req.
- FIFO empty with soc_rvalid_i high: the response is dropped, err_o is set, and err_o clears only on reset.
- Simultaneous push and pop are allowed and leave the count unchanged.
- MAX_OUTSTANDING = 1 reproduces the behaviour of the earlier single-transaction arbiter, with round-robin instead of fixed priority.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_conflict_o [31:0]: counts cycles in which two or more m_req_i bits are high.
  - stat_stall_o [31:0]: counts cycles in which soc_req_o is high and soc_gnt_i is low.
- Both counters saturate at all-ones and reset to 0.
- When not defined, neither the ports nor the logic exist.

Decomposition:
- Package ram_arbiter_pkg holds:
  - arb_state_t enum {ARB, LOCK}.
  - Function rr_pick(req, ptr), returning the winner index and a valid flag.
- One sub-module, ram_arbiter_id_fifo:
  - Synchronous FIFO, depth MAX_OUTSTANDING, width IDX_W.
  - Outputs full, empty, head.

Test Plan:
- NUM_PORTS=4, ports 0 and 2 request continuously, soc_gnt_i tied high, rvalid one cycle after each grant → grants alternate 0,2,0,2; each m_rvalid_o goes to the matching port.
- Port 1 requests address 0x100 with soc_gnt_i low for 3 cycles while port 0 rises in cycle 1 → soc_addr_o stays 0x100 until the grant; port 1 is granted first and port 0 next.
- MAX_OUTSTANDING=2, three back-to-back requests, rvalid withheld → two grants issue, then soc_req_o is held low; the first rvalid pops the FIFO and the third grant issues in the cycle after.
- Ports 3 then 1 are granted, followed by two rvalids with data 0xA, 0xB → m_rvalid_o[3] with 0xA, then m_rvalid_o[1] with 0xB.
- soc_rvalid_i pulses with nothing outstanding → no m_rvalid_o bit asserts, err_o = 1 and stays 1 until rst_ni is low for one edge.
- rst_ni low with two transactions outstanding → after reset the FIFO is empty, rr_ptr = 0, and a later request from ports 0 and 1 together grants port 0 first.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and the round-robin pick function for the N-port RAM arbiter.
// Latency: purely combinational helpers; backpressure: not applicable.
package ram_arbiter_pkg;

    localparam int RR_MAX_PORTS = 16;
    localparam int RR_IDX_W     = 4;
    localparam int RR_CNT_W     = RR_IDX_W + 1;

    typedef logic [RR_CNT_W-1:0] rr_cnt_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                vld;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req scanning ptr, ptr+1, ... modulo num (num <= 16, ptr < num).
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     ptr,
        input rr_cnt_t                 num
    );
        rr_pick_t res;
        rr_cnt_t  cand;
        res = '0;
        for (int i = 0; i < RR_MAX_PORTS; i++) begin
            cand = {1'b0, ptr} + rr_cnt_t'(i);
            if (cand >= num) begin
                cand = cand - num;
            end
            if (!res.vld && (rr_cnt_t'(i) < num) && req[cand[RR_IDX_W-1:0]]) begin
                res.vld = 1'b1;
                res.idx = cand[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arbiter_id_fifo.sv
// In-order FIFO of port IDs for bus transactions awaiting rvalid.
// Latency: head valid the cycle after push; push and pop may share a cycle.
// Backpressure: caller gates pushes with full_o; push-when-full and pop-when-empty are ignored.
module ram_arbiter_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push_en) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_arbiter_rr.sv
// Round-robin N-port to 1 OBI arbiter with in-order response routing; RAM_ARB_STATS_EN adds stat counters.
// Latency: zero added cycles on request and response paths; a grant lets a new request issue next cycle.
// Backpressure: soc_gnt_i stalls the winner (locked until granted); a full ID FIFO holds soc_req_o low.
module ram_arbiter_rr
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int SOC_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IDX_W           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,

    input  logic [NUM_PORTS-1:0]                     m_req_i,
    input  logic [NUM_PORTS-1:0][SOC_ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_PORTS-1:0]                     m_we_i,
    input  logic [NUM_PORTS-1:0][3:0]                m_be_i,
    input  logic [NUM_PORTS-1:0][31:0]               m_wdata_i,
    output logic [NUM_PORTS-1:0]                     m_gnt_o,
    output logic [NUM_PORTS-1:0]                     m_rvalid_o,
    output logic [31:0]                              m_rdata_o,

    output logic                                     soc_req_o,
    input  logic                                     soc_gnt_i,
    output logic [SOC_ADDR_WIDTH-1:0]                soc_addr_o,
    output logic                                     soc_we_o,
    output logic [3:0]                               soc_be_o,
    output logic [31:0]                              soc_wdata_o,
    input  logic                                     soc_rvalid_i,
    input  logic [31:0]                              soc_rdata_i,

    output logic                                     err_o
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0]                              stat_conflict_o,
    output logic [31:0]                              stat_stall_o
`endif
);

    localparam rr_cnt_t          NUM_C     = rr_cnt_t'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]         locked_idx_q, locked_idx_d;
    logic                     err_q, err_d;

    logic [RR_MAX_PORTS-1:0]  req_ext;
    logic [RR_IDX_W-1:0]      ptr_ext;
    rr_pick_t                 pick;
    logic [IDX_W-1:0]         winner;
    logic                     win_req;
    logic                     handshake;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [IDX_W-1:0]         fifo_head;

    logic                     unused_pick_bits;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_PORTS-1:0] = m_req_i;
        ptr_ext                = '0;
        ptr_ext[IDX_W-1:0]     = rr_ptr_q;
        pick                   = rr_pick(req_ext, ptr_ext, NUM_C);
    end

    assign unused_pick_bits = ^pick.idx;

    // LOCK replays the stalled winner so the bus address stays stable until gnt.
    assign winner  = (state_q == LOCK) ? locked_idx_q : pick.idx[IDX_W-1:0];
    assign win_req = (state_q == LOCK) ? m_req_i[locked_idx_q] : pick.vld;

    always_comb begin
        soc_req_o    = 1'b0;
        soc_addr_o   = '0;
        soc_we_o     = 1'b0;
        soc_be_o     = '0;
        soc_wdata_o  = '0;
        m_gnt_o      = '0;
        handshake    = 1'b0;
        fifo_push    = 1'b0;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        locked_idx_d = locked_idx_q;

        // Full is checked before any same-cycle pop, so rvalid never reaches req.
        soc_req_o = win_req && !fifo_full;

        if (soc_req_o) begin
            soc_addr_o  = m_addr_i[winner];
            soc_we_o    = m_we_i[winner];
            soc_be_o    = m_be_i[winner];
            soc_wdata_o = m_wdata_i[winner];
        end

        handshake = soc_req_o && soc_gnt_i;

        if (handshake) begin
            m_gnt_o[winner] = 1'b1;
            fifo_push       = 1'b1;
            rr_ptr_d        = (winner == LAST_PORT) ? '0 : winner + IDX_W'(1);
            state_d         = ARB;
        end else if ((state_q == ARB) && soc_req_o) begin
            locked_idx_d = winner;
            state_d      = LOCK;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        fifo_pop   = 1'b0;
        err_d      = err_q;

        if (soc_rvalid_i) begin
            if (!fifo_empty) begin
                m_rvalid_o[fifo_head] = 1'b1;
                m_rdata_o             = soc_rdata_i;
                fifo_pop              = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            locked_idx_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            locked_idx_q <= locked_idx_d;
            err_q        <= err_d;
        end
    end

    ram_arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (fifo_push),
        .push_dat_i (winner),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

`ifdef RAM_ARB_STATS_EN
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic        multi_req;

    assign multi_req = |(m_req_i & (m_req_i - NUM_PORTS'(1)));

    always_comb begin
        stat_conflict_d = stat_conflict_q;
        stat_stall_d    = stat_stall_q;
        if (multi_req && (stat_conflict_q != '1)) begin
            stat_conflict_d = stat_conflict_q + 32'd1;
        end
        if (soc_req_o && !soc_gnt_i && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_conflict_q <= '0;
            stat_stall_q    <= '0;
        end else begin
            stat_conflict_q <= stat_conflict_d;
            stat_stall_q    <= stat_stall_d;
        end
    end

    assign stat_conflict_o = stat_conflict_q;
    assign stat_stall_o    = stat_stall_q;
`endif

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench for ram_arbiter_rr (4 ports, 2 outstanding) with a port-ID response scoreboard.
module tb_ram_arbiter_rr;

    logic              clk_i;
    logic              rst_ni;
    logic [3:0]        m_req_i;
    logic [3:0][31:0]  m_addr_i;
    logic [3:0]        m_we_i;
    logic [3:0][3:0]   m_be_i;
    logic [3:0][31:0]  m_wdata_i;
    logic [3:0]        m_gnt_o;
    logic [3:0]        m_rvalid_o;
    logic [31:0]       m_rdata_o;
    logic              soc_req_o;
    logic              soc_gnt_i;
    logic [31:0]       soc_addr_o;
    logic              soc_we_o;
    logic [3:0]        soc_be_o;
    logic [31:0]       soc_wdata_o;
    logic              soc_rvalid_i;
    logic [31:0]       soc_rdata_i;
    logic              err_o;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    ram_arbiter_rr #(
        .NUM_PORTS       (4),
        .SOC_ADDR_WIDTH  (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m_req_i      (m_req_i),
        .m_addr_i     (m_addr_i),
        .m_we_i       (m_we_i),
        .m_be_i       (m_be_i),
        .m_wdata_i    (m_wdata_i),
        .m_gnt_o      (m_gnt_o),
        .m_rvalid_o   (m_rvalid_o),
        .m_rdata_o    (m_rdata_o),
        .soc_req_o    (soc_req_o),
        .soc_gnt_i    (soc_gnt_i),
        .soc_addr_o   (soc_addr_o),
        .soc_we_o     (soc_we_o),
        .soc_be_o     (soc_be_o),
        .soc_wdata_o  (soc_wdata_o),
        .soc_rvalid_i (soc_rvalid_i),
        .soc_rdata_i  (soc_rdata_i),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant check; the expected port is queued for the matching response.
    task automatic chk_grant(input string tag, input int port);
        chk(tag, 32'(m_gnt_o), 32'(1) << port);
        exp_q.push_back(port);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] data);
        int p;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=response expected=no_outstanding_port", tag);
        end
        if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            chk({tag, "_port"}, 32'(m_rvalid_o), 32'(1) << p);
            chk({tag, "_data"}, m_rdata_o, data);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        m_req_i      = '0;
        m_addr_i[0]  = 32'h200;
        m_addr_i[1]  = 32'h100;
        m_addr_i[2]  = 32'h300;
        m_addr_i[3]  = 32'h400;
        m_we_i       = 4'b0010;
        m_be_i[0]    = 4'h3;
        m_be_i[1]    = 4'hF;
        m_be_i[2]    = 4'h3;
        m_be_i[3]    = 4'h3;
        m_wdata_i    = '0;
        m_wdata_i[1] = 32'hDEADBEEF;
        soc_gnt_i    = 1'b0;
        soc_rvalid_i = 1'b0;
        soc_rdata_i  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(soc_req_o), 32'd0);
        chk("rst_gnt", 32'(m_gnt_o), 32'd0);
        chk("rst_rvalid", 32'(m_rvalid_o), 32'd0);
        chk("rst_rdata", m_rdata_o, 32'd0);
        chk("rst_addr", soc_addr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Ports 0 and 2 alternate with rvalid one cycle behind each grant
        m_req_i   = 4'b0101;
        soc_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            soc_rvalid_i = (i > 0);
            soc_rdata_i  = 32'h1000 + 32'(i);
            #1;
            if (i > 0) chk_rsp("alt_rsp", 32'h1000 + 32'(i));
            chk_grant("alt_gnt", (i % 2 == 0) ? 0 : 2);
            chk("alt_addr", soc_addr_o, (i % 2 == 0) ? 32'h200 : 32'h300);
            tick();
        end
        m_req_i      = '0;
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h1004;
        #1;
        chk_rsp("alt_rsp_last", 32'h1004);
        chk("alt_idle_req", 32'(soc_req_o), 32'd0);
        tick();
        soc_rvalid_i = 1'b0;

        // Port 1 stalled 3 cycles; port 0 joins but must wait
        m_req_i = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) m_req_i = 4'b0011;
            soc_gnt_i = (c == 3);
            #1;
            chk("lock_req", 32'(soc_req_o), 32'd1);
            chk("lock_addr", soc_addr_o, 32'h100);
            chk("lock_we", 32'(soc_we_o), 32'd1);
            chk("lock_be", 32'(soc_be_o), 32'hF);
            chk("lock_wdata", soc_wdata_o, 32'hDEADBEEF);
            if (c < 3) chk("lock_nogrant", 32'(m_gnt_o), 32'd0);
            else       chk_grant("lock_gnt1", 1);
            tick();
        end
        m_req_i = 4'b0001;
        #1;
        chk_grant("lock_gnt0", 0);
        chk("lock_addr0", soc_addr_o, 32'h200);
        chk("lock_we0", 32'(soc_we_o), 32'd0);
        tick();
        m_req_i      = '0;
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h21;
        #1;
        chk_rsp("lock_rsp1", 32'h21);
        tick();
        soc_rdata_i = 32'h22;
        #1;
        chk_rsp("lock_rsp0", 32'h22);
        tick();
        soc_rvalid_i = 1'b0;

        // FIFO full: third request waits for a pop, then issues the next cycle
        m_req_i = 4'b1000;
        #1;
        chk_grant("full_g1", 3);
        tick();
        chk_grant("full_g2", 3);
        tick();
        chk("full_req_lo", 32'(soc_req_o), 32'd0);
        chk("full_gnt_lo", 32'(m_gnt_o), 32'd0);
        tick();
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h31;
        #1;
        chk_rsp("full_rsp1", 32'h31);
        chk("full_req_on_pop", 32'(soc_req_o), 32'd0);
        tick();
        soc_rvalid_i = 1'b0;
        #1;
        chk_grant("full_g3", 3);
        tick();
        m_req_i      = '0;
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h32;
        #1;
        chk_rsp("full_rsp2", 32'h32);
        tick();
        soc_rdata_i = 32'h33;
        #1;
        chk_rsp("full_rsp3", 32'h33);
        tick();
        soc_rvalid_i = 1'b0;

        // In-order routing: port 3 then port 1
        m_req_i = 4'b1000;
        #1;
        chk_grant("ord_g3", 3);
        tick();
        m_req_i = 4'b0010;
        #1;
        chk_grant("ord_g1", 1);
        tick();
        m_req_i      = '0;
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'hA;
        #1;
        chk_rsp("ord_rsp_a", 32'hA);
        tick();
        soc_rdata_i = 32'hB;
        #1;
        chk_rsp("ord_rsp_b", 32'hB);
        tick();
        soc_rvalid_i = 1'b0;
        #1;
        chk("ord_idle_rvalid", 32'(m_rvalid_o), 32'd0);
        chk("ord_idle_rdata", m_rdata_o, 32'd0);

        // Spurious rvalid sets sticky error
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h77;
        #1;
        chk("err_no_rvalid", 32'(m_rvalid_o), 32'd0);
        chk("err_no_rdata", m_rdata_o, 32'd0);
        chk("err_before", 32'(err_o), 32'd0);
        tick();
        soc_rvalid_i = 1'b0;
        #1;
        chk("err_set", 32'(err_o), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(err_o), 32'd1);

        // Reset with two outstanding; rr_ptr left at 1 beforehand
        m_req_i = 4'b1000;
        #1;
        chk_grant("rst_g3", 3);
        tick();
        m_req_i = 4'b0001;
        #1;
        chk_grant("rst_g0", 0);
        tick();
        m_req_i = '0;
        rst_ni  = 1'b0;
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        #1;
        chk("rst2_err", 32'(err_o), 32'd0);
        chk("rst2_req", 32'(soc_req_o), 32'd0);
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h55;
        #1;
        chk("rst2_fifo_empty", 32'(m_rvalid_o), 32'd0);
        tick();
        soc_rvalid_i = 1'b0;
        #1;
        chk("rst2_err_set", 32'(err_o), 32'd1);
        m_req_i = 4'b0011;
        #1;
        chk_grant("rst2_first", 0);
        tick();
        m_req_i = 4'b0010;
        #1;
        chk_grant("rst2_next", 1);
        tick();
        m_req_i      = '0;
        soc_rvalid_i = 1'b1;
        soc_rdata_i  = 32'h61;
        #1;
        chk_rsp("rst2_rsp0", 32'h61);
        tick();
        soc_rdata_i = 32'h62;
        #1;
        chk_rsp("rst2_rsp1", 32'h62);
        tick();
        soc_rvalid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
